string_matcher_param: RTL and testbench
=======================================

STRING_MATCHER_PARAM -- requirements
Module: string_matcher_param

Interface
REQ-001 SHALL expose parameter SYM_W, default 2, symbol width in bits (2 = legacy a/b pair).
REQ-002 SHALL expose parameter MAX_LEN, default 8, maximum pattern length in symbols (2..32).
REQ-003 SHALL expose parameter CNT_W, default 16, match-counter width.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  level; high = matcher enabled, low = return to IDLE.
REQ-007 sym_valid  input  1  symbol strobe; sym sampled only when high.
REQ-008 sym  input  SYM_W  incoming stream symbol.
REQ-009 cfg_we  input  1  pattern-memory write strobe.
REQ-010 cfg_idx  input  clog2(MAX_LEN)  pattern position; 0 = oldest symbol of the match.
REQ-011 cfg_sym  input  SYM_W  pattern symbol written at cfg_idx.
REQ-012 cfg_len  input  clog2(MAX_LEN)+1  active pattern length.
REQ-013 overlap  input  1  1 = overlapping matches allowed, 0 = history cleared after each match.
REQ-014 y_val  output  1  one-cycle match pulse.
REQ-015 match_cnt  output  CNT_W  saturating count of matches since reset or last start rise.
REQ-016 busy  output  1  high in FILL or SCAN.
REQ-017 cfg_err  output  1  sticky; set on a rejected config write or illegal cfg_len.

Function
REQ-018 The FSM SHALL have states IDLE, FILL, SCAN.
REQ-019 IDLE: cfg_we writes the pattern; cfg_len is latched on start rise; rise with legal cfg_len (1..MAX_LEN) -> FILL, otherwise stay in IDLE and set cfg_err.
REQ-020 FILL: each sym_valid shifts sym into a MAX_LEN history window and increments a fill count; reaching the latched length -> SCAN, with a compare on that same symbol.
REQ-021 SCAN: each sym_valid shifts the window and compares the newest len symbols against pattern[0..len-1].
REQ-022 y_val SHALL pulse exactly one cycle, in the cycle after the completing symbol is sampled (latency 1).
REQ-023 On a match with overlap=1 the FSM SHALL stay in SCAN; with overlap=0 it SHALL clear the fill count and go to FILL.
REQ-024 Cycles without sym_valid SHALL NOT shift, compare or change state.
REQ-025 start low in FILL or SCAN SHALL go to IDLE next cycle, clear the window and fill count, and keep match_cnt.
REQ-026 A start rise SHALL clear match_cnt.
REQ-027 match_cnt SHALL increment with each y_val and saturate at all-ones.
REQ-028 cfg_we while busy SHALL be ignored and set cfg_err; cfg_idx >= MAX_LEN SHALL be ignored and set cfg_err.
REQ-029 cfg_err SHALL clear only on reset.
REQ-030 cfg_we together with a start rise SHALL commit the write before the length latch; the pattern takes effect in that run.
REQ-031 len=1 SHALL match on every equal symbol and skip FILL dwell; FILL completes on the first symbol.

Reset
REQ-032 Asserted reset SHALL force IDLE, y_val=0, match_cnt=0, busy=0, cfg_err=0, window and fill count 0, without waiting for clk.
REQ-033 Pattern memory SHALL reset to all zeros and latched length to 1.
REQ-034 Deassertion SHALL be synchronised so that the first active edge follows two clk rising edges.

Structure
REQ-035 A shared package string_pkg SHALL hold the state enum (IDLE/FILL/SCAN) and the default SYM_W, MAX_LEN and CNT_W constants.
REQ-036 The window compare SHALL be one sub-module, pattern_window_cmp, combinational: window, pattern and len in, hit out.

Verification
REQ-037 Pattern "0,1,1" (SYM_W=2, len 3), overlap=1, stream 0,1,1,0,1,1 -> y_val after the 3rd and 6th symbols, match_cnt=2.
REQ-038 Pattern "1,1", stream 1,1,1,1: overlap=1 -> 3 pulses; overlap=0 -> 2 pulses.
REQ-039 Start with cfg_len=0 -> stays IDLE, cfg_err=1, busy=0; cfg_we while busy -> pattern unchanged, cfg_err=1.
REQ-040 Drop start mid-FILL after 2 of 3 symbols, restart, send the last pattern symbol only -> no y_val.
REQ-041 Assert reset between clock edges during SCAN -> all outputs 0 immediately, IDLE.
REQ-042 CNT_W=2, five matches -> match_cnt saturates at 3.

Source files
------------

// File: rtl/string_pkg.sv
// rtl/string_pkg.sv - shared types and default sizes for the parameterised string matcher.
package string_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_SCAN = 2'd2
  } state_e;

  localparam int DEF_SYM_W   = 2;
  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/pattern_window_cmp.sv
// rtl/pattern_window_cmp.sv - compares the newest len window symbols against pattern[0..len-1].
// window slot 0 is the newest symbol; pattern slot 0 is the oldest symbol of a match.
module pattern_window_cmp #(
  parameter int SYM_W   = 2,
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input  logic [MAX_LEN*SYM_W-1:0] window,
  input  logic [MAX_LEN*SYM_W-1:0] pattern,
  input  logic [LEN_W-1:0]         len,
  output logic                     hit
);

  // window slot i lines up with pattern slot j when i + j + 1 == len
  always_comb begin
    hit = (len != '0);
    for (int i = 0; i < MAX_LEN; i++) begin
      for (int j = 0; j < MAX_LEN; j++) begin
        if ((i + j + 1 == int'(len)) &&
            (window[i*SYM_W +: SYM_W] != pattern[j*SYM_W +: SYM_W])) begin
          hit = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/string_matcher_param.sv
// rtl/string_matcher_param.sv - streaming pattern matcher with programmable pattern,
// length and overlap mode; one-cycle match pulse and saturating match counter.
module string_matcher_param
  import string_pkg::*;
#(
  parameter  int SYM_W   = DEF_SYM_W,
  parameter  int MAX_LEN = DEF_MAX_LEN,
  parameter  int CNT_W   = DEF_CNT_W,
  localparam int IDX_W   = $clog2(MAX_LEN),
  localparam int LEN_W   = IDX_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sym_valid,
  input  logic [SYM_W-1:0] sym,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [SYM_W-1:0] cfg_sym,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             overlap,
  output logic             y_val,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy,
  output logic             cfg_err
);

  localparam int WIN_W = MAX_LEN * SYM_W;

  logic [1:0]       rst_sync_q, rst_sync_d;
  logic             rst_n;
  state_e           state_q, state_d;
  logic             start_q;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [WIN_W-1:0] pat_q, pat_d;
  logic             y_val_q, y_val_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [WIN_W-1:0] win_shift;
  logic [LEN_W-1:0] fill_inc;
  logic             hit, idx_bad, len_ok, start_rise, step, cmp_en;

  // reset asserts immediately but releases only after two clock edges
  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= '0;
    else        rst_sync_q <= rst_sync_d;
  end

  assign rst_n = rst_sync_q[1];

  generate
    if ((1 << IDX_W) > MAX_LEN) begin : g_idx_chk
      assign idx_bad = (cfg_idx >= IDX_W'(MAX_LEN));
    end else begin : g_idx_full
      assign idx_bad = 1'b0;
    end
  endgenerate

  assign len_ok     = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  assign start_rise = start && !start_q && (state_q == ST_IDLE);
  assign win_shift  = {win_q[WIN_W-SYM_W-1:0], sym};
  assign fill_inc   = fill_q + LEN_W'(1);
  assign step       = busy && start && sym_valid;
  assign cmp_en     = step && ((state_q == ST_SCAN) || (fill_inc == len_q));

  pattern_window_cmp #(
    .SYM_W   (SYM_W),
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_cmp (
    .window  (win_shift),
    .pattern (pat_q),
    .len     (len_q),
    .hit     (hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_rise && len_ok) state_d = ST_FILL;
      default: begin
        if (!start)      state_d = ST_IDLE;
        else if (cmp_en) state_d = (hit && !overlap) ? ST_FILL : ST_SCAN;
      end
    endcase
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    y_val     = y_val_q;
    match_cnt = cnt_q;
    cfg_err   = err_q;
  end

  always_comb begin
    win_d   = win_q;
    fill_d  = fill_q;
    len_d   = len_q;
    pat_d   = pat_q;
    y_val_d = 1'b0;
    cnt_d   = cnt_q;
    err_d   = err_q;

    if (start_rise) begin
      len_d = cfg_len;
      if (!len_ok) err_d = 1'b1;
    end

    if (busy && !start) begin
      win_d  = '0;
      fill_d = '0;
    end else if (step) begin
      win_d   = win_shift;
      y_val_d = cmp_en && hit;
      if (!cmp_en)                fill_d = fill_inc;
      else if (hit && !overlap)   fill_d = '0;
      else                        fill_d = len_q;
    end

    if (start_rise)                             cnt_d = '0;
    else if (y_val_d && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);

    if (cfg_we) begin
      if (busy || idx_bad) err_d = 1'b1;
      else                 pat_d[int'(cfg_idx)*SYM_W +: SYM_W] = cfg_sym;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      len_q   <= LEN_W'(1);
      fill_q  <= '0;
      win_q   <= '0;
      pat_q   <= '0;
      y_val_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      start_q <= start;
      len_q   <= len_d;
      fill_q  <= fill_d;
      win_q   <= win_d;
      pat_q   <= pat_d;
      y_val_q <= y_val_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_string_matcher_param.sv
// tb/tb_string_matcher_param.sv - scoreboard bench for string_matcher_param.
module tb_string_matcher_param;

  localparam int SYM_W   = 2;
  localparam int MAX_LEN = 8;
  localparam int IDX_W   = 3;
  localparam int LEN_W   = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             sym_valid = 1'b0;
  logic [SYM_W-1:0] sym = '0;
  logic             cfg_we = 1'b0;
  logic [IDX_W-1:0] cfg_idx = '0;
  logic [SYM_W-1:0] cfg_sym = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             overlap = 1'b0;

  logic        y_val, busy, cfg_err;
  logic [15:0] match_cnt;
  logic        y_val_s, busy_s, cfg_err_s;
  logic [1:0]  match_cnt_s;

  always #5 clk = ~clk;

  string_matcher_param dut (
    .clk(clk), .reset(reset), .start(start), .sym_valid(sym_valid), .sym(sym),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sym(cfg_sym), .cfg_len(cfg_len),
    .overlap(overlap), .y_val(y_val), .match_cnt(match_cnt), .busy(busy), .cfg_err(cfg_err)
  );

  string_matcher_param #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .sym_valid(sym_valid), .sym(sym),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sym(cfg_sym), .cfg_len(cfg_len),
    .overlap(overlap), .y_val(y_val_s), .match_cnt(match_cnt_s), .busy(busy_s), .cfg_err(cfg_err_s)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int seen  = 0;
  int exp_q[$];

  // reference model state
  int m_pat[MAX_LEN];
  int m_hist[$];
  int m_len = 1;
  int m_cnt = 0;
  bit m_ov  = 1'b0;
  bit m_run = 1'b0;
  bit m_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // monitor: every pulse must match the oldest outstanding expectation
  initial begin
    forever begin
      @(negedge clk);
      if (y_val || y_val_s) check("y_val_sat_agree", y_val_s, y_val);
      if (y_val) begin
        seen++;
        if (exp_q.size() == 0) check("unexpected_y_val", 1, 0);
        else                   check("y_val_cycle", cyc, exp_q.pop_front());
      end else if (exp_q.size() > 0 && exp_q[0] <= cyc) begin
        void'(exp_q.pop_front());
        check("missed_y_val", 0, 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int idx, input int s);
    cfg_we  = 1'b1;
    cfg_idx = idx[IDX_W-1:0];
    cfg_sym = s[SYM_W-1:0];
    if (!m_run) m_pat[idx] = s;
    else        m_err = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic go(input int len, input bit ov);
    start   = 1'b1;
    cfg_len = len[LEN_W-1:0];
    overlap = ov;
    m_len   = len;
    m_ov    = ov;
    m_cnt   = 0;
    m_hist.delete();
    if (len >= 1 && len <= MAX_LEN) m_run = 1'b1;
    else                            m_err = 1'b1;
    tick();
  endtask

  task automatic stop();
    start = 1'b0;
    m_run = 1'b0;
    m_hist.delete();
    tick();
  endtask

  task automatic send(input int s);
    bit eq;
    sym_valid = 1'b1;
    sym       = s[SYM_W-1:0];
    if (m_run) begin
      m_hist.push_back(s);
      if (m_hist.size() > m_len) void'(m_hist.pop_front());
      if (m_hist.size() == m_len) begin
        eq = 1'b1;
        for (int i = 0; i < m_len; i++) if (m_hist[i] != m_pat[i]) eq = 1'b0;
        if (eq) begin
          exp_q.push_back(cyc + 1);
          m_cnt++;
          if (!m_ov) m_hist.delete();
        end
      end
    end
    tick();
    sym_valid = 1'b0;
  endtask

  task automatic check_cnt(input string tag);
    check({tag, "_cnt"},     match_cnt,   (m_cnt > 65535) ? 65535 : m_cnt);
    check({tag, "_cnt_sat"}, match_cnt_s, (m_cnt > 3) ? 3 : m_cnt);
    check({tag, "_cfg_err"}, cfg_err,     m_err);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_y_val"},   y_val,     0);
    check({tag, "_cnt"},     match_cnt, 0);
    check({tag, "_busy"},    busy,      0);
    check({tag, "_cfg_err"}, cfg_err,   0);
    check({tag, "_busy_s"},  busy_s,    0);
    check({tag, "_err_s"},   cfg_err_s, 0);
  endtask

  initial begin
    int base, len, ns;
    bit ov;

    #1 reset = 1'b0;
    #2 check_idle_outputs("reset_state");
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    check_idle_outputs("after_release");

    // pattern 0,1,1 with overlap: pulses after 3rd and 6th symbol
    wr(0, 0); wr(1, 1); wr(2, 1);
    stop();
    go(3, 1'b1);
    check("busy_after_start", busy, 1);
    base = seen;
    foreach (m_pat[i]) if (i < 0) m_pat[i] = 0;
    send(0); send(1); tick(); send(1); send(0); tick(); tick(); send(1); send(1);
    tick();
    check("p011_pulses", seen - base, 2);
    check_cnt("p011");

    // pattern 1,1: overlapping vs non-overlapping
    stop();
    wr(0, 1); wr(1, 1);
    go(2, 1'b1);
    base = seen;
    repeat (4) send(1);
    tick();
    check("p11_overlap_pulses", seen - base, 3);
    check_cnt("p11_ov");
    stop();
    go(2, 1'b0);
    base = seen;
    repeat (4) send(1);
    tick();
    check("p11_nooverlap_pulses", seen - base, 2);
    check_cnt("p11_noov");

    // partial fill discarded by start drop
    stop();
    wr(0, 0); wr(1, 1); wr(2, 1);
    go(3, 1'b1);
    send(0); send(1);
    stop();
    go(3, 1'b1);
    base = seen;
    send(1);
    tick();
    check("restart_no_pulse", seen - base, 0);
    check_cnt("restart");

    // config write while busy is rejected, pattern unchanged
    wr(0, 3);
    check("busy_write_err", cfg_err, 1);
    base = seen;
    send(0); send(1); send(1);
    tick();
    check("busy_write_pat_kept", seen - base, 1);
    check_cnt("busy_write");

    // asynchronous reset mid-cycle while a pulse is showing
    send(0); send(1); send(1);
    check("pre_reset_y_val", y_val, 1);
    check("pre_reset_busy", busy, 1);
    #1;
    exp_q.delete();
    start = 1'b0;
    reset = 1'b0;
    #1 check_idle_outputs("async_reset");
    foreach (m_pat[i]) m_pat[i] = 0;
    m_len = 1; m_cnt = 0; m_run = 1'b0; m_err = 1'b0;
    m_hist.delete();
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    check_idle_outputs("post_reset");

    // illegal lengths
    go(0, 1'b0);
    check("len0_busy", busy, 0);
    check("len0_err", cfg_err, 1);
    tick();
    check("len0_still_idle", busy, 0);
    stop();
    go(9, 1'b0);
    check("len9_busy", busy, 0);
    check_cnt("len9");

    // len 1 and counter saturation
    stop();
    wr(0, 2);
    go(1, 1'b0);
    base = seen;
    send(2); send(2); send(0); send(2); tick(); send(2); send(2);
    tick();
    check("len1_pulses", seen - base, 5);
    check("sat_cnt_full", match_cnt, 5);
    check("sat_cnt_small", match_cnt_s, 3);

    // randomized runs against the model
    for (int r = 0; r < 8; r++) begin
      stop();
      len = $urandom_range(1, MAX_LEN);
      ov  = 1'($urandom_range(0, 1));
      for (int k = 0; k < len; k++) wr(k, $urandom_range(0, 1));
      go(len, ov);
      ns = $urandom_range(40, 80);
      for (int k = 0; k < ns; k++) begin
        if ($urandom_range(0, 7) == 0) send($urandom_range(2, 3));
        else                           send($urandom_range(0, 1));
        repeat ($urandom_range(0, 2)) tick();
        if ($urandom_range(0, 40) == 0) begin
          tick();
          stop();
          go(len, ov);
        end
      end
      tick();
      check_cnt($sformatf("rand%0d", r));
    end

    stop();
    repeat (3) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
